// File: rtl/phase_decimator.sv
// Block-mean decimator for a PLL phase-detector output. It declares lock after
// enough consecutive small-mean blocks and emits block means through a valid/ready port.
module phase_decimator #(
    parameter int unsigned DECIM    = 64,
    parameter int unsigned LOCK_THR = 2048,
    parameter int unsigned LOCK_CNT = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tick_i,
    input  logic signed [15:0] phase_i,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic signed [15:0] data_o,
    output logic               lock_o,
    output logic [1:0]         state_o,
    output logic               overflow_o
);

    localparam int unsigned SH = $clog2(DECIM);
    localparam int unsigned AW = 16 + SH;
    localparam int unsigned GW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    state_t               r_state, w_nxt_state;
    logic signed [AW-1:0] r_acc, w_nxt_acc;
    logic [SH-1:0]        r_cnt, w_nxt_cnt;
    logic [GW-1:0]        r_good, w_nxt_good;
    logic                 r_valid, w_nxt_valid;
    logic signed [15:0]   r_data, w_nxt_data;
    logic                 r_ovf, w_nxt_ovf;
    logic                 r_lock, w_nxt_lock;

    logic signed [AW-1:0] w_sum;
    logic signed [AW-1:0] w_shift;
    logic signed [15:0]   w_mean;
    logic [15:0]          w_abs;
    logic                 w_good;
    logic                 w_last;
    logic                 w_xfer;

    // Block mean of the completing sample, with |-32768| saturated to 32767.
    always_comb begin
        w_sum   = r_acc + AW'(phase_i);
        w_shift = w_sum >>> SH;
        w_mean  = $signed(w_shift[15:0]);
        if (w_mean == 16'sh8000) begin
            w_abs = 16'h7FFF;
        end else if (w_mean[15]) begin
            w_abs = 16'(-w_mean);
        end else begin
            w_abs = 16'(w_mean);
        end
        w_good = (w_abs < 16'(LOCK_THR));
        w_last = tick_i && (r_cnt == SH'(DECIM - 1));
        w_xfer = r_valid && ready_i;
    end

    // Next-state and output-register logic; stop beats start, start beats everything else.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_acc   = r_acc;
        w_nxt_cnt   = r_cnt;
        w_nxt_good  = r_good;
        w_nxt_valid = r_valid;
        w_nxt_data  = r_data;
        w_nxt_ovf   = r_ovf;

        if (stop_i) begin
            w_nxt_state = ST_IDLE;
            w_nxt_acc   = '0;
            w_nxt_cnt   = '0;
            w_nxt_good  = '0;
            w_nxt_valid = 1'b0;
        end else if (start_i) begin
            w_nxt_state = ST_ACQ;
            w_nxt_acc   = '0;
            w_nxt_cnt   = '0;
            w_nxt_good  = '0;
            w_nxt_valid = 1'b0;
            w_nxt_ovf   = 1'b0;
        end else begin
            if (w_xfer) begin
                w_nxt_valid = 1'b0;
            end
            if ((r_state != ST_IDLE) && tick_i) begin
                if (w_last) begin
                    w_nxt_acc = '0;
                    w_nxt_cnt = '0;
                end else begin
                    w_nxt_acc = w_sum;
                    w_nxt_cnt = r_cnt + SH'(1);
                end
            end
            if (w_last) begin
                case (r_state)
                    ST_ACQ: begin
                        if (!w_good) begin
                            w_nxt_good = '0;
                        end else if ((r_good + GW'(1)) == GW'(LOCK_CNT)) begin
                            w_nxt_good  = '0;
                            w_nxt_state = ST_LOCK;
                        end else begin
                            w_nxt_good = r_good + GW'(1);
                        end
                    end
                    ST_LOCK: begin
                        if (!w_good) begin
                            w_nxt_good  = '0;
                            w_nxt_state = ST_ACQ;
                        end else if (r_valid && !ready_i) begin
                            w_nxt_ovf = 1'b1;
                        end else begin
                            w_nxt_data  = w_mean;
                            w_nxt_valid = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
        w_nxt_lock = (w_nxt_state == ST_LOCK);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_good  <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_lock  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_acc   <= w_nxt_acc;
            r_cnt   <= w_nxt_cnt;
            r_good  <= w_nxt_good;
            r_valid <= w_nxt_valid;
            r_data  <= w_nxt_data;
            r_ovf   <= w_nxt_ovf;
            r_lock  <= w_nxt_lock;
        end
    end

    assign valid_o    = r_valid;
    assign data_o     = r_data;
    assign lock_o     = r_lock;
    assign state_o    = r_state;
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_phase_decimator.sv
// Scoreboard bench for phase_decimator (DECIM=4, LOCK_THR=100, LOCK_CNT=2).
// Expected block means are queued by the stimulus and popped by a transfer monitor.
module tb_phase_decimator;

    logic               clk_i;
    logic               rst_i;
    logic               tick_i;
    logic signed [15:0] phase_i;
    logic               start_i;
    logic               stop_i;
    logic               ready_i;
    logic               valid_o;
    logic signed [15:0] data_o;
    logic               lock_o;
    logic [1:0]         state_o;
    logic               overflow_o;

    int n_cmp;
    int n_err;
    int exp_q[$];

    phase_decimator #(
        .DECIM   (4),
        .LOCK_THR(100),
        .LOCK_CNT(2)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .tick_i    (tick_i),
        .phase_i   (phase_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .ready_i   (ready_i),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .lock_o    (lock_o),
        .state_o   (state_o),
        .overflow_o(overflow_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus, driven just after an edge and held across the next one.
    task automatic step(input logic t, input int p, input logic st = 1'b0, input logic sp = 1'b0);
        tick_i  = t;
        phase_i = 16'(p);
        start_i = st;
        stop_i  = sp;
        @(posedge clk_i);
        #1;
        tick_i  = 1'b0;
        start_i = 1'b0;
        stop_i  = 1'b0;
    endtask

    task automatic ticks(input int n, input int p);
        for (int i = 0; i < n; i++) step(1'b1, p);
    endtask

    // Transfer monitor: every valid&&ready seen before an edge is one accepted block.
    always @(negedge clk_i) begin
        if (rst_i === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL xfer_unexpected: got data_o=%0d, expected no transfer (t=%0t)",
                         $signed(data_o), $time);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (int'($signed(data_o)) != e) begin
                    n_err++;
                    $display("FAIL xfer_data: got %0d, expected %0d (t=%0t)",
                             $signed(data_o), e, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst_i   = 1'b1;
        tick_i  = 1'b0;
        phase_i = '0;
        start_i = 1'b0;
        stop_i  = 1'b0;
        ready_i = 1'b1;

        // Asynchronous reset between edges
        #12 rst_i = 1'b0;
        #1;
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_data", int'(data_o), 0);
        chk("rst_lock", int'(lock_o), 0);
        chk("rst_state", int'(state_o), 0);
        chk("rst_ovf", int'(overflow_o), 0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        step(1'b1, 40);
        chk("idle_ignores_tick", int'(state_o), 0);

        // Acquire and lock on constant 40
        step(1'b0, 0, 1'b1);
        chk("start_state", int'(state_o), 1);
        ticks(7, 40);
        chk("pre_lock_state", int'(state_o), 1);
        ticks(1, 40);
        chk("lock_state", int'(state_o), 2);
        chk("lock_o", int'(lock_o), 1);
        ticks(3, 40);
        chk("no_valid_before_12", int'(valid_o), 0);
        exp_q.push_back(40);
        ticks(1, 40);
        chk("valid_after_12", int'(valid_o), 1);
        chk("data_after_12", int'($signed(data_o)), 40);
        step(1'b0, 0);
        chk("valid_drop_after_xfer", int'(valid_o), 0);

        // Bad block drops lock, then relock
        ticks(4, -200);
        chk("bad_state", int'(state_o), 1);
        chk("bad_lock", int'(lock_o), 0);
        chk("bad_no_valid", int'(valid_o), 0);
        ticks(8, 0);
        chk("relock_state", int'(state_o), 2);

        // Backpressure: second block dropped, overflow sticks
        ready_i = 1'b0;
        exp_q.push_back(40);
        ticks(8, 40);
        chk("bp_valid", int'(valid_o), 1);
        chk("bp_data", int'($signed(data_o)), 40);
        chk("bp_ovf", int'(overflow_o), 1);
        ready_i = 1'b1;
        step(1'b0, 0);
        chk("bp_valid_after_xfer", int'(valid_o), 0);

        // Floor rounding and -32768 saturation
        ticks(3, -1);
        exp_q.push_back(-2);
        ticks(1, -2);
        chk("floor_data", int'($signed(data_o)), -2);
        ticks(4, -32768);
        chk("min_bad_state", int'(state_o), 1);
        chk("min_bad_lock", int'(lock_o), 0);
        ticks(8, 0);
        chk("relock2_state", int'(state_o), 2);

        // Transfer and new load on the same edge
        ready_i = 1'b0;
        exp_q.push_back(8);
        ticks(4, 8);
        ticks(3, 12);
        ready_i = 1'b1;
        exp_q.push_back(12);
        ticks(1, 12);
        chk("same_edge_valid", int'(valid_o), 1);
        chk("same_edge_data", int'($signed(data_o)), 12);
        chk("ovf_sticky", int'(overflow_o), 1);
        step(1'b0, 0);
        chk("same_edge_drain", int'(valid_o), 0);

        // Start on a completing tick: nothing emitted, counters restart
        ticks(3, 0);
        step(1'b1, 0, 1'b1);
        chk("start_cmpl_state", int'(state_o), 1);
        chk("start_cmpl_ovf", int'(overflow_o), 0);
        chk("start_cmpl_valid", int'(valid_o), 0);
        ticks(7, 0);
        chk("restart_pre_lock", int'(state_o), 1);
        ticks(1, 0);
        chk("restart_lock", int'(state_o), 2);

        // Stop, and stop winning over start
        step(1'b0, 0, 1'b0, 1'b1);
        chk("stop_state", int'(state_o), 0);
        chk("stop_lock", int'(lock_o), 0);
        step(1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        chk("stop_wins", int'(state_o), 0);

        // Reset mid-block, stays idle afterwards
        step(1'b0, 0, 1'b1);
        ticks(2, 50);
        #2 rst_i = 1'b0;
        #1;
        chk("midrst_state", int'(state_o), 0);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        ticks(4, 0);
        chk("midrst_idle", int'(state_o), 0);

        step(1'b0, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/phase_decimator.md
PHASE_DECIMATOR -- requirements
Module: phase_decimator

Interface
- REQ-001 SHALL have parameter DECIM, default 64, samples per block (power of two, 2..1024).
- REQ-002 SHALL have parameter LOCK_THR, default 2048, block-mean magnitude limit for "in lock" (1..32767).
- REQ-003 SHALL have parameter LOCK_CNT, default 8, consecutive good blocks to declare lock (1..255).
- REQ-004 SHALL have one clock; reset is asynchronous and active-low.
- REQ-005 clk_i  input  1  system clock.
- REQ-006 rst_i  input  1  asynchronous active-low reset.
- REQ-007 tick_i  input  1  sample strobe; phase_i is valid when high.
- REQ-008 phase_i  input  16 signed  PLL phase-detector (mixer) output.
- REQ-009 start_i  input  1  single-cycle pulse that (re)starts acquisition.
- REQ-010 stop_i  input  1  single-cycle pulse that returns to IDLE.
- REQ-011 ready_i  input  1  downstream accepts data_o.
- REQ-012 valid_o  output  1  data_o holds an unconsumed block mean.
- REQ-013 data_o  output  16 signed  block mean of phase_i.
- REQ-014 lock_o  output  1  high only in LOCKED.
- REQ-015 state_o  output  2  IDLE=0, ACQUIRE=1, LOCKED=2.
- REQ-016 overflow_o  output  1  sticky: a LOCKED block was dropped.

Function
- REQ-017 FSM states: IDLE, ACQUIRE, LOCKED.
- REQ-018 IDLE: ignore tick_i; start_i -> ACQUIRE next cycle.
- REQ-019 In ACQUIRE/LOCKED, each tick_i adds sign-extended phase_i to an accumulator of 16+log2(DECIM) bits; a sample counter counts 0..DECIM-1 and wraps.
- REQ-020 On the tick carrying sample DECIM-1, mean = (acc + phase_i) >>> log2(DECIM) (arithmetic shift, floor rounding); the accumulator clears at the same edge.
- REQ-021 A block is "good" when |mean| < LOCK_THR; |-32768| is taken as 32767.
- REQ-022 ACQUIRE: good block increments the good counter; bad block clears it; when the counter reaches LOCK_CNT, go to LOCKED at that same edge and clear the counter.
- REQ-023 Blocks completed in ACQUIRE, including the one that causes lock, are never emitted.
- REQ-024 LOCKED: a good block is loaded into data_o, and valid_o is asserted in the cycle after the completing tick (latency 1 clk).
- REQ-025 LOCKED: a bad block is not emitted; go to ACQUIRE with the counter cleared; lock_o falls at the same edge; a pending valid_o is kept.
- REQ-026 Handshake: the transfer occurs on a clock edge with valid_o && ready_i; valid_o then falls unless a new block loads at the same edge.
- REQ-027 data_o is stable while valid_o && !ready_i.
- REQ-028 Block completes while valid_o && !ready_i: drop the new block, keep the old data_o, set overflow_o.
- REQ-029 Block completes on the same edge as a transfer: load the new block, keep valid_o high, no overflow.
- REQ-030 start_i in any state: clear accumulator, sample counter, good counter, valid_o, overflow_o; go to ACQUIRE.
- REQ-031 stop_i: clear valid_o and counters; go to IDLE.
- REQ-032 If start_i and stop_i are both high, stop_i wins.
- REQ-033 overflow_o clears only on start_i or reset.

Reset
- REQ-034 rst_i low SHALL immediately force state IDLE, valid_o=0, data_o=0, lock_o=0, state_o=0, overflow_o=0, and clear all counters and the accumulator, independent of clk_i.
- REQ-035 Reset asserted mid-block SHALL discard the partial block; after release the block stays in IDLE until start_i.

Verification (DECIM=4, LOCK_THR=100, LOCK_CNT=2)
- REQ-036 Reset: apply rst_i=0 between edges -> all outputs 0 at once, state_o=0.
- REQ-037 start_i, then 12 ticks of phase_i=40, ready_i=1 -> lock_o=1 and state_o=2 after tick 8; no valid_o before tick 12; valid_o=1 with data_o=40 one clk after tick 12.
- REQ-038 While LOCKED, 4 ticks of -200 -> state_o=1, lock_o=0, no valid_o; then 8 ticks of 0 -> relock.
- REQ-039 LOCKED, ready_i=0, 8 ticks of 40 -> data_o=40 held, overflow_o=1; ready_i=1 -> one transfer, then valid_o=0.
- REQ-040 LOCKED, samples -1,-1,-1,-2 -> data_o=-2 (floor); samples -32768 x4 -> block counts as bad.
- REQ-041 Assert start_i on the same edge as a completing tick -> no emission, all counters cleared, state_o=1.
